multi_adc_serial_rx: RTL
========================

Name: multi_adc_serial_rx

Overview:
- Parametrised successor to the two-channel serial ADC front end.
- Drives a shared serial clock and active-low chip select to NUM_CH identical serial ADCs with one data line each, and deserialises each frame.
- Captures a burst of BURST_LEN conversions, one per sensor_clk rising edge, and presents parallel words with a valid strobe to the downstream force-processing logic.
- Everything runs on clk_20M; ADC_clk is generated internally as a divided, registered signal.

Parameters:
- NUM_CH, 2, number of ADC channels sampled in lockstep.
- DATA_W, 12, result bits per channel.
- FRAME_BITS, 16, ADC_clk rising edges per frame.
- LEAD_BITS, 4, bits discarded before the MSB. LEAD_BITS+DATA_W <= FRAME_BITS.
- SCLK_DIV, 1, ADC_clk half-period in clk_20M cycles, >= 1.
- QUIET_CYC, 2, minimum clk_20M cycles chip_select_n stays high between frames, >= 1.
- BURST_LEN, 128, conversions per burst, >= 1.

Ports:
- clk_20M  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_control  in  1  one-cycle pulse that arms or restarts a burst.
- sensor_clk  in  1  asynchronous conversion trigger; rising edge requests one frame.
- Data  in  NUM_CH  serial data, bit i from ADC i.
- ADC_clk  out  1  serial clock; idle high.
- chip_select_n  out  1  active-low frame enable; idle high.
- pdata  out  NUM_CH*DATA_W  results; channel i in bits [i*DATA_W +: DATA_W].
- pdata_valid  out  1  one-cycle strobe marking pdata updated.
- busy  out  1  high while a burst is armed.
- burst_done  out  1  one-cycle pulse after the last conversion of a burst.
- overrun  out  1  sticky flag; cleared by reset or sample_control.

Behaviour:
- Reset values: ADC_clk=1, chip_select_n=1, pdata=0, pdata_valid=0, busy=0, burst_done=0, overrun=0. FSM goes to IDLE and the burst count is cleared.
- Reset mid-frame aborts the frame immediately; no pdata_valid is produced.
- sensor_clk path: 2-flop synchroniser, then rising-edge detect, giving trig, 3 cycles after the input edge.
- Burst control:
  - sample_control loads remaining=BURST_LEN, sets busy, and clears overrun.
  - sample_control during a burst restarts the count; an in-flight frame still completes and is counted against the new count.
- FSM states:
  - IDLE: trig && busy -> SHIFT. trig && !busy is ignored.
  - SHIFT: chip_select_n=0 and ADC_clk driven low on entry. ADC_clk toggles every SCLK_DIV cycles. On each clk_20M edge where ADC_clk goes 0->1, the registered Data bits are sampled as bit index k, counting from 0.
    - Bits k in [LEAD_BITS, LEAD_BITS+DATA_W-1] shift into per-channel registers, MSB first. Other bits are discarded.
    - After the FRAME_BITS-th rising edge and its high half-period -> DONE.
  - DONE (1 cycle): chip_select_n=1, pdata loaded from the shift registers, pdata_valid=1, remaining decremented.
    - If remaining reaches 0: busy=0, burst_done=1.
    - Then -> QUIET.
  - QUIET: chip_select_n high for QUIET_CYC cycles, then -> IDLE.
- Overrun: trig arriving in SHIFT, DONE or QUIET while busy sets overrun. The trigger is dropped and never queued.
- Frame length: FRAME_BITS*2*SCLK_DIV cycles in SHIFT. Default = 32 cycles.
- Trigger-to-valid latency (sensor_clk input edge to pdata_valid) = 3 + FRAME_BITS*2*SCLK_DIV + 1 cycles. Default = 36.
- pdata holds its value between strobes.
- Simultaneous sample_control and DONE: sample_control wins. remaining=BURST_LEN and busy=1; burst_done is suppressed.

Optional Feature:
- Macro: ADC_ACCUM_EN.
- When defined:
  - Adds output acc_sum, width NUM_CH*(DATA_W+$clog2(BURST_LEN+1)).
  - Adds output acc_valid, 1 bit.
  - Per-channel accumulators clear on sample_control and add each DONE word.
  - On burst completion acc_sum is registered and acc_valid pulses in the same cycle as burst_done.
- When undefined: neither port nor the accumulators exist; all other behaviour is identical.

Test Plan:
- Reset: reset=1, then release -> ADC_clk=1, chip_select_n=1, pdata=0, busy=0, overrun=0.
- Single frame: sample_control, then one sensor_clk edge, with ADC0 model sending 0000_1010_1011_1100 and ADC1 model sending 0000_0101_0100_0011 -> pdata[11:0]=12'hABC, pdata[23:12]=12'h543, pdata_valid 36 cycles after the edge, chip_select_n low for exactly 32 cycles.
- Burst: BURST_LEN=4 with 6 sensor_clk edges 50 cycles apart -> exactly 4 pdata_valid pulses, burst_done with the 4th, busy falls, edges 5-6 ignored.
- Overrun: second sensor_clk edge 10 cycles after the first -> overrun=1, one pdata_valid only; next sample_control clears overrun.
- Parameter sweep: NUM_CH=4, DATA_W=14, LEAD_BITS=2, SCLK_DIV=3 -> correct per-channel words, ADC_clk period 6 cycles, chip_select_n low for 96 cycles.
- Reset mid-frame: assert reset at SHIFT bit 7 -> outputs at reset values, no pdata_valid; with ADC_ACCUM_EN, 4-word burst of 12'h100 -> acc_sum channel 0 = 1024, acc_valid coincident with burst_done.

Source files
------------

// File: rtl/multi_adc_serial_rx_if.sv
// Serial ADC bus plus parallel result bus for multi_adc_serial_rx.
// master = receiver side, slave = ADC/consumer side.
interface multi_adc_serial_rx_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 12
);
  logic [NUM_CH-1:0]        Data;
  logic                     ADC_clk;
  logic                     chip_select_n;
  logic [NUM_CH*DATA_W-1:0] pdata;
  logic                     pdata_valid;
  logic                     busy;
  logic                     burst_done;
  logic                     overrun;

  modport master (
    input  Data,
    output ADC_clk, chip_select_n, pdata, pdata_valid, busy, burst_done, overrun
  );

  modport slave (
    output Data,
    input  ADC_clk, chip_select_n, pdata, pdata_valid, busy, burst_done, overrun
  );
endinterface

// File: rtl/multi_adc_serial_rx.sv
// Multi-channel serial ADC receiver: shared ADC_clk/chip_select_n, burst-counted frames.
// Optional macro ADC_ACCUM_EN adds per-channel burst accumulators (acc_sum/acc_valid).
//
// state | meaning
// IDLE  | waiting for a trigger while a burst is armed
// SHIFT | frame in progress, ADC_clk running, chip_select_n low
// DONE  | one cycle: publish pdata, count the conversion
// QUIET | chip_select_n held high before the next frame
module multi_adc_serial_rx #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int SCLK_DIV   = 1,
  parameter int QUIET_CYC  = 2,
  parameter int BURST_LEN  = 128
) (
  input  logic clk_20M,
  input  logic reset,
  input  logic sample_control,
  input  logic sensor_clk,
`ifdef ADC_ACCUM_EN
  output logic [NUM_CH*(DATA_W+$clog2(BURST_LEN+1))-1:0] acc_sum,
  output logic                                           acc_valid,
`endif
  multi_adc_serial_rx_if.master bus
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int REM_W = $clog2(BURST_LEN + 1);
  localparam int QC_W  = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;

  state_t                   state, state_nxt;
  logic                     sync1, sync2, sync3, trig;
  logic [DIV_W-1:0]         div_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [QC_W-1:0]          quiet_cnt;
  logic [REM_W-1:0]         remaining;
  logic                     adc_clk_q, cs_n_q, pdata_valid_q, busy_q, burst_done_q, overrun_q;
  logic [DATA_W-1:0]        shreg [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] shreg_flat, pdata_q;
  logic                     sclk_tc, rise, done_evt, start_evt, in_frame;

  assign sclk_tc   = (div_cnt == '0);
  assign start_evt = (state == IDLE) && (state_nxt == SHIFT);
  assign done_evt  = (state == SHIFT) && (state_nxt == DONE);
  assign in_frame  = (state == SHIFT) && (state_nxt == SHIFT);

  always_comb begin
    state_nxt = state;
    rise      = 1'b0;
    case (state)
      IDLE:  if (trig && busy_q) state_nxt = SHIFT;
      SHIFT: begin
        if (sclk_tc) begin
          if (!adc_clk_q)
            rise = 1'b1;
          else if (bit_cnt == BIT_W'(FRAME_BITS))
            state_nxt = DONE;
        end
      end
      DONE:  state_nxt = QUIET;
      QUIET: if (quiet_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shreg_flat = '0;
    for (int i = 0; i < NUM_CH; i++) shreg_flat[i*DATA_W +: DATA_W] = shreg[i];
  end

  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // sensor_clk is asynchronous: two flops, then a registered rising-edge detect
  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      trig  <= 1'b0;
    end else begin
      sync1 <= sensor_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      trig  <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      adc_clk_q <= 1'b1;
      cs_n_q    <= 1'b1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      quiet_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) shreg[i] <= '0;
    end else begin
      cs_n_q <= (state_nxt != SHIFT);
      if (start_evt) begin
        adc_clk_q <= 1'b0;
        div_cnt   <= DIV_W'(SCLK_DIV - 1);
        bit_cnt   <= '0;
      end else if (in_frame) begin
        if (sclk_tc) begin
          adc_clk_q <= ~adc_clk_q;
          div_cnt   <= DIV_W'(SCLK_DIV - 1);
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
        if (rise) bit_cnt <= bit_cnt + BIT_W'(1);
      end else begin
        adc_clk_q <= 1'b1;
      end

      // only the data window of the frame reaches the shift registers, MSB first
      if (rise && bit_cnt >= BIT_W'(LEAD_BITS) && bit_cnt < BIT_W'(LEAD_BITS + DATA_W))
        for (int i = 0; i < NUM_CH; i++) shreg[i] <= {shreg[i][DATA_W-2:0], bus.Data[i]};

      if (state == DONE)
        quiet_cnt <= QC_W'(QUIET_CYC - 1);
      else if (state == QUIET && quiet_cnt != '0)
        quiet_cnt <= quiet_cnt - QC_W'(1);
    end
  end

  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      pdata_q       <= '0;
      pdata_valid_q <= 1'b0;
      remaining     <= '0;
      busy_q        <= 1'b0;
      burst_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      pdata_valid_q <= done_evt;
      burst_done_q  <= 1'b0;
      if (done_evt) pdata_q <= shreg_flat;

      // a restart coinciding with the end of a frame re-arms a full burst
      if (sample_control) begin
        remaining <= REM_W'(BURST_LEN);
        busy_q    <= 1'b1;
      end else if (done_evt && remaining != '0) begin
        remaining <= remaining - REM_W'(1);
        if (remaining == REM_W'(1)) begin
          busy_q       <= 1'b0;
          burst_done_q <= 1'b1;
        end
      end

      if (sample_control)
        overrun_q <= 1'b0;
      else if (trig && busy_q && state != IDLE)
        overrun_q <= 1'b1;
    end
  end

`ifdef ADC_ACCUM_EN
  localparam int ACC_W = DATA_W + REM_W;

  logic [ACC_W-1:0]        acc [NUM_CH];
  logic [NUM_CH*ACC_W-1:0] acc_sum_q;
  logic                    acc_valid_q;

  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      acc_sum_q   <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      if (sample_control) begin
        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else if (done_evt) begin
        for (int i = 0; i < NUM_CH; i++) acc[i] <= acc[i] + ACC_W'(shreg[i]);
        if (remaining == REM_W'(1)) begin
          acc_valid_q <= 1'b1;
          for (int i = 0; i < NUM_CH; i++)
            acc_sum_q[i*ACC_W +: ACC_W] <= acc[i] + ACC_W'(shreg[i]);
        end
      end
    end
  end

  assign acc_sum   = acc_sum_q;
  assign acc_valid = acc_valid_q;
`endif

  assign bus.ADC_clk       = adc_clk_q;
  assign bus.chip_select_n = cs_n_q;
  assign bus.pdata         = pdata_q;
  assign bus.pdata_valid   = pdata_valid_q;
  assign bus.busy          = busy_q;
  assign bus.burst_done    = burst_done_q;
  assign bus.overrun       = overrun_q;

endmodule
